ifid_pipe_reg: RTL and testbench

IFID_PIPE_REG -- requirements
Module: ifid_pipe_reg

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pipe_skid_buf.sv | 97 +++++++++
 rtl/ifid_pipe_reg.sv | 82 ++++++++
 tb/tb_ifid_pipe_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble instruction, instruction field bit positions
// and the occupancy encoding used by the pipeline skid buffers.
package cpu_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hF000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RD_MSB     = 25;
    localparam int unsigned RD_LSB     = 21;
    localparam int unsigned RS_MSB     = 20;
    localparam int unsigned RS_LSB     = 16;
    localparam int unsigned RT_MSB     = 15;
    localparam int unsigned RT_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned IMM16_MSB  = 15;
    localparam int unsigned IMM26_MSB  = 25;
    localparam int unsigned IMM21_MSB  = 20;
    localparam int unsigned SIDX_MSB   = 25;
    localparam int unsigned SIDX_LSB   = 20;
    localparam int unsigned XCOOR_MSB  = 19;
    localparam int unsigned XCOOR_LSB  = 10;
    localparam int unsigned YCOOR_MSB  = 9;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_MAIN  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry main/skid buffer with flush. in_ready comes straight from the
// occupancy register, so it never depends combinationally on out_ready.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t  state_q, state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         consume;
    logic         load_main;
    logic         load_skid;
    logic         skid_to_main;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d   = BUF_MAIN;
                        load_main = 1'b1;
                    end
                end
                BUF_MAIN: begin
                    if (consume) begin
                        if (accept) begin
                            load_main = 1'b1;
                        end else begin
                            state_d = BUF_EMPTY;
                        end
                    end else if (accept) begin
                        state_d   = BUF_FULL;
                        load_skid = 1'b1;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so nothing new can arrive alongside the drain
                    if (consume) begin
                        state_d      = BUF_MAIN;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: skid-buffered instruction hand-off with flush,
// bubble insertion, instruction field decode and a saturating stall counter.
module ifid_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned   IW       = 32,
    parameter int unsigned   AW       = 32,
    parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEFAULT),
    parameter int unsigned   CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [5:0]    out_opcode,
    output logic [4:0]    out_rd,
    output logic [4:0]    out_rs,
    output logic [4:0]    out_rt,
    output logic [4:0]    out_shamt,
    output logic [15:0]   out_imm16,
    output logic [25:0]   out_imm26,
    output logic [20:0]   out_imm21,
    output logic [5:0]    out_sidx,
    output logic [9:0]    out_xcoor,
    output logic [9:0]    out_ycoor,
    output logic          out_bubble,
    output logic [CW-1:0] stall_cnt
);

    logic [IW+AW-1:0] buf_data;
    logic [IW-1:0]    held_instr;
    logic             main_valid;

    pipe_skid_buf #(
        .W (IW + AW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_instr, in_pc}),
        .out_valid (main_valid),
        .out_ready (out_ready),
        .out_data  (buf_data)
    );

    // PC is passed through even when invalid so it keeps its last loaded value
    assign {held_instr, out_pc} = buf_data;

    assign out_valid  = main_valid;
    assign out_bubble = !main_valid;
    assign out_instr  = main_valid ? held_instr : NOP_WORD;

    assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign out_rd     = out_instr[RD_MSB:RD_LSB];
    assign out_rs     = out_instr[RS_MSB:RS_LSB];
    assign out_rt     = out_instr[RT_MSB:RT_LSB];
    assign out_shamt  = out_instr[SHAMT_MSB:SHAMT_LSB];
    assign out_imm16  = out_instr[IMM16_MSB:0];
    assign out_imm26  = out_instr[IMM26_MSB:0];
    assign out_imm21  = out_instr[IMM21_MSB:0];
    assign out_sidx   = out_instr[SIDX_MSB:SIDX_LSB];
    assign out_xcoor  = out_instr[XCOOR_MSB:XCOOR_LSB];
    assign out_ycoor  = out_instr[YCOOR_MSB:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Directed self-checking bench for ifid_pipe_reg (CW overridden to 4).
module tb_ifid_pipe_reg;

    localparam logic [31:0] NOP = 32'hF000_0000;
    localparam logic [31:0] IA  = 32'h1234_5678;
    localparam logic [31:0] IB  = 32'h0421_0000;
    localparam logic [31:0] IC  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd, out_rs, out_rt, out_shamt;
    logic [15:0] out_imm16;
    logic [25:0] out_imm26;
    logic [20:0] out_imm21;
    logic [5:0]  out_sidx;
    logic [9:0]  out_xcoor, out_ycoor;
    logic        out_bubble;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    ifid_pipe_reg #(
        .IW (32),
        .AW (32),
        .CW (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_shamt  (out_shamt),
        .out_imm16  (out_imm16),
        .out_imm26  (out_imm26),
        .out_imm21  (out_imm21),
        .out_sidx   (out_sidx),
        .out_xcoor  (out_xcoor),
        .out_ycoor  (out_ycoor),
        .out_bubble (out_bubble),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", out_instr, NOP); end
        checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble: got %b want 1", out_bubble); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
        checks++; if (out_opcode !== 6'h3C) begin errors++; $display("FAIL reset_opcode: got %h want 3c", out_opcode); end
        checks++; if (out_imm26 !== 26'h0) begin errors++; $display("FAIL reset_imm26: got %h want 0", out_imm26); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h0;
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== IA || out_pc !== 32'h0) begin errors++; $display("FAIL stream_A: got v=%b %h@%h want 1 %h@0", out_valid, out_instr, out_pc, IA); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_A: got %b want 1", in_ready); end
        checks++; if (out_opcode !== 6'h04 || out_rd !== 5'h11 || out_rs !== 5'h14 || out_rt !== 5'h0A || out_shamt !== 5'h19) begin
            errors++; $display("FAIL fields_reg: got op=%h rd=%h rs=%h rt=%h sh=%h want 04 11 14 0a 19", out_opcode, out_rd, out_rs, out_rt, out_shamt);
        end
        checks++; if (out_imm16 !== 16'h5678 || out_imm26 !== 26'h234_5678 || out_imm21 !== 21'h14_5678) begin
            errors++; $display("FAIL fields_imm: got %h %h %h want 5678 2345678 145678", out_imm16, out_imm26, out_imm21);
        end
        checks++; if (out_sidx !== 6'h23 || out_xcoor !== 10'h115 || out_ycoor !== 10'h278) begin
            errors++; $display("FAIL fields_coor: got %h %h %h want 23 115 278", out_sidx, out_xcoor, out_ycoor);
        end
        in_instr = IB; in_pc = 32'h4;
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== IB || out_pc !== 32'h4) begin errors++; $display("FAIL stream_B: got v=%b %h@%h want 1 %h@4", out_valid, out_instr, out_pc, IB); end
        in_instr = IC; in_pc = 32'h8;
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== IC || out_pc !== 32'h8) begin errors++; $display("FAIL stream_C: got v=%b %h@%h want 1 %h@8", out_valid, out_instr, out_pc, IC); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_C: got %b want 1", in_ready); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_bubble !== 1'b1 || out_instr !== NOP) begin errors++; $display("FAIL stream_drain: got v=%b b=%b %h want 0 1 %h", out_valid, out_bubble, out_instr, NOP); end
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL stream_pc_hold: got %h want 8", out_pc); end
    endtask

    task automatic test_hold();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h0;
        step();
        out_ready = 1'b0; in_instr = IB; in_pc = 32'h4;
        step();
        checks++; if (out_instr !== IA || out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_main: got v=%b %h@%h want 1 %h@0", out_valid, out_instr, out_pc, IA); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL hold_stall: got %0d want 1", stall_cnt); end
        in_instr = IC; in_pc = 32'h8;
        step();
        checks++; if (out_instr !== IA || in_ready !== 1'b0) begin errors++; $display("FAIL hold_second: got %h rdy=%b want %h rdy=0", out_instr, in_ready, IA); end
        out_ready = 1'b1;
        step();
        checks++; if (out_instr !== IB || out_pc !== 32'h4 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_B: got %h@%h rdy=%b want %h@4 rdy=1", out_instr, out_pc, in_ready, IB); end
        step();
        checks++; if (out_instr !== IC || out_pc !== 32'h8 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_release_C: got v=%b %h@%h want 1 %h@8", out_valid, out_instr, out_pc, IC); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_empty: got %b want 0", out_valid); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL hold_stall_final: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h10;
        step();
        out_ready = 1'b0; in_instr = IB; in_pc = 32'h14;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got rdy=%b want 0", in_ready); end
        in_instr = IC; in_pc = 32'h18; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_bubble !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got v=%b b=%b rdy=%b want 0 1 1", out_valid, out_bubble, in_ready); end
        checks++; if (out_instr !== 32'hF000_0000 || out_opcode !== 6'h3C) begin errors++; $display("FAIL flush_nop: got %h op=%h want f0000000 3c", out_instr, out_opcode); end
        checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL flush_pc_hold: got %h want 10", out_pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_lost: got v=%b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h20;
        step();
        in_instr = IB; in_pc = 32'h24; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== NOP) begin errors++; $display("FAIL simul_flush: got v=%b rdy=%b %h want 0 1 %h", out_valid, in_ready, out_instr, NOP); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_discard: got v=%b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h30;
        step();
        in_valid = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_start: got %0d want 0", stall_cnt); end
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (stall_cnt !== ((i > 15) ? 4'd15 : 4'(i))) begin
                errors++; $display("FAIL sat_cycle%0d: got %0d want %0d", i, stall_cnt, (i > 15) ? 15 : i);
            end
        end
        checks++; if (out_instr !== IA || out_pc !== 32'h30) begin errors++; $display("FAIL sat_held: got %h@%h want %h@30", out_instr, out_pc, IA); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = IA; in_pc = 32'h40;
        step();
        out_ready = 1'b0; in_instr = IB; in_pc = 32'h44;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (stall_cnt !== 4'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got stall=%0d rdy=%b want 2 0", stall_cnt, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== NOP || out_bubble !== 1'b1) begin errors++; $display("FAIL rstmid_out: got v=%b %h b=%b want 0 %h 1", out_valid, out_instr, out_bubble, NOP); end
        checks++; if (stall_cnt !== 4'd0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL rstmid_state: got stall=%0d rdy=%b pc=%h want 0 1 0", stall_cnt, in_ready, out_pc); end
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got v=%b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_flush();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
